// File: rtl/fifo_level.sv
// Show-ahead register-file FIFO with arbitrary depth, fill level, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_level #(
  parameter int pBITS   = 8,
  parameter int pDEPTH  = 5,
  parameter int pAFULL  = 4,
  parameter int pAEMPTY = 1
) (
  input  logic                         iclk,
  input  logic                         ireset_n,
  input  logic                         iclr,
  input  logic                         iwr,
  input  logic [pBITS-1:0]             iw_data,
  input  logic                         ird,
  output logic [pBITS-1:0]             or_data,
  output logic                         oempty,
  output logic                         ofull,
  output logic                         oalmost_empty,
  output logic                         oalmost_full,
  output logic [$clog2(pDEPTH+1)-1:0]  ocount,
  output logic                         ooverflow,
  output logic                         ounderflow
);

  localparam int PW = $clog2(pDEPTH);
  localparam int CW = $clog2(pDEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(pDEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(pDEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(pAFULL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(pAEMPTY);

  if (pDEPTH < 2) begin : g_bad_depth
    $error("fifo_level: pDEPTH must be >= 2");
  end
  if ((pAFULL < 1) || (pAFULL > pDEPTH)) begin : g_bad_afull
    $error("fifo_level: pAFULL must be in 1..pDEPTH");
  end
  if ((pAEMPTY < 0) || (pAEMPTY >= pDEPTH)) begin : g_bad_aempty
    $error("fifo_level: pAEMPTY must be in 0..pDEPTH-1");
  end

  // Non-power-of-2 depth, so pointers wrap explicitly at the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  logic [pBITS-1:0] mem_q [pDEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             aempty_q, aempty_d, afull_q, afull_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_acc_s, rd_acc_s, mem_we_s;

  assign wr_acc_s = iwr & (~full_q | ird);
  assign rd_acc_s = ird & ~empty_q;
  assign mem_we_s = wr_acc_s & ~iclr;

  // Next-state: flush dominates; flags are computed from the next count.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (iclr) begin
      wptr_d  = {PW{1'b0}};
      rptr_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_d = ptr_inc(wptr_q);
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_acc_s) begin
        rptr_d = ptr_inc(rptr_q);
      end else begin
        rptr_d = rptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (iwr & full_q & ~ird);
      unf_d = unf_q | (ird & empty_q);
    end
    empty_d  = (count_d == {CW{1'b0}});
    full_d   = (count_d == DEPTH_C);
    aempty_d = (count_d <= AEMPTY_C);
    afull_d  = (count_d >= AFULL_C);
  end

  // Pointer, level and flag registers.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      wptr_q   <= {PW{1'b0}};
      rptr_q   <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge iclk) begin
    if (mem_we_s) begin
      mem_q[wptr_q] <= iw_data;
    end
  end

  assign or_data       = mem_q[rptr_q];
  assign oempty        = empty_q;
  assign ofull         = full_q;
  assign oalmost_empty = aempty_q;
  assign oalmost_full  = afull_q;
  assign ocount        = count_q;
  assign ooverflow     = ovf_q;
  assign ounderflow    = unf_q;

endmodule
